// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI request scheduler.
//   state_t     : scheduler FSM states
//   CFG_*       : field layout of a per-requester config word {cpol, cpha, div[2:0]}
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    HOLD,
    RELEASE
  } state_t;

  localparam int unsigned CFG_W       = 5;
  localparam int unsigned CFG_CPOL    = 4;
  localparam int unsigned CFG_CPHA    = 3;
  localparam int unsigned CFG_DIV_LSB = 0;

endpackage

// File: rtl/spi_req_scheduler_if.sv
// Bundle of requester-side and SPI_Master-side signals of the scheduler.
//   req/req_data/req_cfg        : requester inputs (packed per requester)
//   gnt/done/err/rx_data        : requester results
//   spi_*/cs_n                  : drive SPI_Master and chip selects
//   spi_done/spi_rx_data        : SPI_Master completion inputs
// Modports: slave = scheduler, master = requesters/SPI_Master side.
interface spi_req_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned Data_Width = 8
);
  import spi_ctrl_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*Data_Width-1:0] req_data;
  logic [NUM_REQ*CFG_W-1:0]      req_cfg;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic [Data_Width-1:0]         rx_data;
  logic [Data_Width-1:0]         spi_data;
  logic                          spi_data_valid;
  logic                          spi_cpol;
  logic                          spi_cpha;
  logic [2:0]                    spi_div;
  logic [NUM_REQ-1:0]            cs_n;
  logic                          spi_done;
  logic [Data_Width-1:0]         spi_rx_data;

  modport slave (
    input  req, req_data, req_cfg, spi_done, spi_rx_data,
    output gnt, done, err, rx_data, spi_data, spi_data_valid,
           spi_cpol, spi_cpha, spi_div, cs_n
  );

  modport master (
    output req, req_data, req_cfg, spi_done, spi_rx_data,
    input  gnt, done, err, rx_data, spi_data, spi_data_valid,
           spi_cpol, spi_cpha, spi_div, cs_n
  );

endinterface

// File: rtl/spi_req_scheduler_arb.sv
// Combinational round-robin select: first set req bit at or after ptr_i,
// wrapping around.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   gnt_o   : one-hot winner
//   valid_o : any request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       valid_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  always_comb begin
    logic [IDX_W-1:0] j;
    logic             found;
    gnt_o = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/spi_req_scheduler.sv
// Round-robin scheduler sharing one SPI_Master between NUM_REQ requesters.
// Latches the winner's data/config, drives its chip select with setup/hold
// spacing, launches the frame, waits for spi_done or watchdog timeout and
// returns rx data + status.
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : scheduler side (slave) of spi_req_scheduler_if
module spi_req_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned Data_Width = 8,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic                 clk,
  input logic                 rst,
  spi_req_scheduler_if.slave  bus
);
  import spi_ctrl_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + CS_SETUP + CS_HOLD + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d, ptr_q, ptr_d;
  logic                  err_pend_q, err_pend_d;
  logic [Data_Width-1:0] rxbuf_q, rxbuf_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d, done_q, done_d, cs_n_q, cs_n_d;
  logic                  err_q, err_d, dv_q, dv_d;
  logic [Data_Width-1:0] rx_q, rx_d, data_q, data_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [2:0]            div_q, div_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic                  arb_valid;
  logic [IDX_W-1:0]      arb_idx;
  logic [CFG_W-1:0]      win_cfg;
  logic [NUM_REQ-1:0]    sel_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) arb_idx = IDX_W'(k);
    end
  end

  assign win_cfg = bus.req_cfg[arb_idx*CFG_W +: CFG_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    err_pend_d = err_pend_q;
    rxbuf_d    = rxbuf_q;
    data_d     = data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    case (state_q)
      IDLE: if (arb_valid) begin
        idx_d   = arb_idx;
        data_d  = bus.req_data[arb_idx*Data_Width +: Data_Width];
        cpol_d  = win_cfg[CFG_CPOL];
        cpha_d  = win_cfg[CFG_CPHA];
        div_d   = win_cfg[CFG_DIV_LSB +: 3];
        cnt_d   = '0;
        state_d = SETUP;
      end
      SETUP: if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
        cnt_d   = '0;
        state_d = START;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      // spi_done wins over a watchdog expiry in the same cycle.
      WAIT: if (bus.spi_done) begin
        rxbuf_d    = bus.spi_rx_data;
        err_pend_d = 1'b0;
        cnt_d      = '0;
        state_d    = HOLD;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        rxbuf_d    = '0;
        err_pend_d = 1'b1;
        cnt_d      = '0;
        state_d    = HOLD;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      HOLD: if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
        cnt_d   = '0;
        state_d = RELEASE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RELEASE: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    sel_d        = '0;
    sel_d[idx_d] = 1'b1;
    gnt_d  = (state_d inside {SETUP, START, WAIT, HOLD}) ? sel_d : '0;
    cs_n_d = ~gnt_d;
    dv_d   = (state_d == START);
    done_d = (state_d == RELEASE) ? sel_d : '0;
    err_d  = (state_d == RELEASE) && err_pend_d;
    rx_d   = (state_d == RELEASE) ? rxbuf_d : rx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      err_pend_q <= 1'b0;
      rxbuf_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      cs_n_q     <= '1;
      err_q      <= 1'b0;
      dv_q       <= 1'b0;
      rx_q       <= '0;
      data_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      err_pend_q <= err_pend_d;
      rxbuf_q    <= rxbuf_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      err_q      <= err_d;
      dv_q       <= dv_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.rx_data        = rx_q;
  assign bus.spi_data       = data_q;
  assign bus.spi_data_valid = dv_q;
  assign bus.spi_cpol       = cpol_q;
  assign bus.spi_cpha       = cpha_q;
  assign bus.spi_div        = div_q;
  assign bus.cs_n           = cs_n_q;

endmodule

// File: tb/tb_spi_req_scheduler.sv
// Directed self-checking bench for spi_req_scheduler (NUM_REQ=4, 8-bit,
// CS_SETUP=2, CS_HOLD=2, TIMEOUT=1024).
module tb_spi_req_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spi_req_scheduler_if #(.NUM_REQ(4), .Data_Width(8)) bus ();

  spi_req_scheduler #(
    .NUM_REQ(4), .Data_Width(8), .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req = '0;
    bus.spi_done = 1'b0;
    bus.spi_rx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.gnt, bus.done, bus.err, bus.spi_data_valid} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctl: got gnt=%b done=%b err=%b dv=%b expected all 0",
               bus.gnt, bus.done, bus.err, bus.spi_data_valid);
    end
    checks++;
    if (bus.cs_n !== 4'b1111) begin
      failures++; $display("FAIL reset_cs_n: got %b expected 1111", bus.cs_n);
    end
    checks++;
    if ({bus.spi_data, bus.rx_data, bus.spi_cpol, bus.spi_cpha, bus.spi_div} !== 21'b0) begin
      failures++;
      $display("FAIL reset_data: got spi_data=%h rx=%h cpol=%b cpha=%b div=%0d expected 0",
               bus.spi_data, bus.rx_data, bus.spi_cpol, bus.spi_cpha, bus.spi_div);
    end
  endtask

  task automatic test_single();
    bus.req_data[7:0] = 8'hA5;
    bus.req_cfg[4:0]  = 5'b10_010;
    bus.req = 4'b0001;                       // cycle 0
    step(1);                                 // cycle 1
    checks++;
    if (bus.gnt !== 4'b0001 || bus.cs_n !== 4'b1110) begin
      failures++; $display("FAIL single_grant: got gnt=%b cs_n=%b expected 0001/1110", bus.gnt, bus.cs_n);
    end
    checks++;
    if (bus.spi_cpol !== 1'b1 || bus.spi_div !== 3'd2 || bus.spi_data_valid !== 1'b0) begin
      failures++; $display("FAIL single_cfg: got cpol=%b div=%0d dv=%b expected 1/2/0",
                           bus.spi_cpol, bus.spi_div, bus.spi_data_valid);
    end
    step(2);                                 // cycle 3
    checks++;
    if (bus.spi_data_valid !== 1'b1 || bus.spi_data !== 8'hA5) begin
      failures++; $display("FAIL single_launch: got dv=%b data=%h expected 1/a5", bus.spi_data_valid, bus.spi_data);
    end
    step(1);                                 // cycle 4
    bus.req = 4'b0000;
    checks++;
    if (bus.spi_data_valid !== 1'b0) begin
      failures++; $display("FAIL single_dv_pulse: got dv=%b expected 0", bus.spi_data_valid);
    end
    step(19);                                // cycle 23
    bus.spi_done = 1'b1;
    bus.spi_rx_data = 8'h3C;
    step(1);                                 // cycle 24
    bus.spi_done = 1'b0;
    checks++;
    if (bus.done !== 4'b0000 || bus.cs_n !== 4'b1110) begin
      failures++; $display("FAIL single_hold: got done=%b cs_n=%b expected 0000/1110", bus.done, bus.cs_n);
    end
    step(2);                                 // cycle 26
    checks++;
    if (bus.done !== 4'b0001 || bus.rx_data !== 8'h3C || bus.err !== 1'b0) begin
      failures++; $display("FAIL single_done: got done=%b rx=%h err=%b expected 0001/3c/0",
                           bus.done, bus.rx_data, bus.err);
    end
    checks++;
    if (bus.cs_n !== 4'b1111 || bus.gnt !== 4'b0000 || bus.spi_cpol !== 1'b1 || bus.spi_div !== 3'd2) begin
      failures++; $display("FAIL single_release: got cs_n=%b gnt=%b cpol=%b div=%0d expected 1111/0000/1/2",
                           bus.cs_n, bus.gnt, bus.spi_cpol, bus.spi_div);
    end
    step(1);
    checks++;
    if (bus.done !== 4'b0000) begin
      failures++; $display("FAIL single_done_pulse: got done=%b expected 0000", bus.done);
    end
  endtask

  task automatic test_timeout();
    bus.req = 4'b0001;                       // cycle 0
    step(1029);
    checks++;
    if (bus.done !== 4'b0000 || bus.cs_n !== 4'b1110) begin
      failures++; $display("FAIL timeout_early: got done=%b cs_n=%b expected 0000/1110", bus.done, bus.cs_n);
    end
    step(1);                                 // cycle 1030
    bus.req = 4'b0000;
    checks++;
    if (bus.done !== 4'b0001 || bus.err !== 1'b1 || bus.rx_data !== 8'h00 || bus.cs_n !== 4'b1111) begin
      failures++; $display("FAIL timeout_done: got done=%b err=%b rx=%h cs_n=%b expected 0001/1/00/1111",
                           bus.done, bus.err, bus.rx_data, bus.cs_n);
    end
    step(1);
  endtask

  task automatic test_timeout_coincident();
    bus.req = 4'b0001;                       // cycle 0
    step(1027);                              // last WAIT cycle
    bus.spi_done = 1'b1;
    bus.spi_rx_data = 8'h96;
    step(1);
    bus.spi_done = 1'b0;
    bus.req = 4'b0000;
    step(2);                                 // cycle 1030
    checks++;
    if (bus.done !== 4'b0001 || bus.err !== 1'b0 || bus.rx_data !== 8'h96) begin
      failures++; $display("FAIL coincident_done: got done=%b err=%b rx=%h expected 0001/0/96",
                           bus.done, bus.err, bus.rx_data);
    end
    step(1);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    int n;
    do_reset();
    for (int s = 0; s < 4; s++) bus.req_data[s*8 +: 8] = 8'(8'h10 + s);
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % 4);
      n = 0;
      while (bus.spi_data_valid !== 1'b1 && n < 10) begin
        step(1);
        n++;
      end
      checks++;
      if (n >= 10) begin
        failures++; $display("FAIL rr_launch_%0d: got no spi_data_valid expected one within 10 cycles", t);
      end
      checks++;
      if (bus.gnt !== exp || bus.cs_n !== ~exp || bus.spi_data !== 8'(8'h10 + t % 4)) begin
        failures++; $display("FAIL rr_grant_%0d: got gnt=%b cs_n=%b data=%h expected %b/%b/%h",
                             t, bus.gnt, bus.cs_n, bus.spi_data, exp, ~exp, 8'(8'h10 + t % 4));
      end
      step(3);
      bus.spi_done = 1'b1;
      bus.spi_rx_data = 8'(t);
      step(1);
      bus.spi_done = 1'b0;
      step(2);
      checks++;
      if (bus.done !== exp || bus.rx_data !== 8'(t)) begin
        failures++; $display("FAIL rr_done_%0d: got done=%b rx=%h expected %b/%h", t, bus.done, bus.rx_data, exp, 8'(t));
      end
      step(1);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.cs_n !== 4'b1111) begin
        failures++; $display("FAIL rr_gap_%0d: got gnt=%b cs_n=%b expected 0000/1111", t, bus.gnt, bus.cs_n);
      end
    end
    bus.req = 4'b0000;
    step(10);
  endtask

  task automatic test_latched();
    do_reset();
    bus.req_data[23:16] = 8'h5A;
    bus.req_cfg[14:10]  = 5'b01_101;
    bus.req = 4'b0100;                       // cycle 0
    step(5);                                 // cycle 5, WAIT
    bus.req = 4'b0000;
    bus.req_data[23:16] = 8'hFF;
    bus.req_cfg[14:10]  = 5'b10_000;
    step(3);                                 // cycle 8
    bus.spi_done = 1'b1;
    bus.spi_rx_data = 8'hC3;
    step(1);
    bus.spi_done = 1'b0;
    checks++;
    if (bus.spi_data !== 8'h5A || bus.spi_cpol !== 1'b0 || bus.spi_cpha !== 1'b1 || bus.spi_div !== 3'd5) begin
      failures++; $display("FAIL latched_cfg: got data=%h cpol=%b cpha=%b div=%0d expected 5a/0/1/5",
                           bus.spi_data, bus.spi_cpol, bus.spi_cpha, bus.spi_div);
    end
    step(2);                                 // cycle 11
    checks++;
    if (bus.done !== 4'b0100 || bus.rx_data !== 8'hC3 || bus.err !== 1'b0) begin
      failures++; $display("FAIL latched_done: got done=%b rx=%h err=%b expected 0100/c3/0",
                           bus.done, bus.rx_data, bus.err);
    end
    step(2);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      failures++; $display("FAIL latched_no_regrant: got gnt=%b expected 0000", bus.gnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0001;
    step(5);                                 // WAIT
    checks++;
    if (bus.cs_n !== 4'b1110) begin
      failures++; $display("FAIL arst_pre: got cs_n=%b expected 1110", bus.cs_n);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cs_n !== 4'b1111 || bus.gnt !== 4'b0000 || bus.spi_data_valid !== 1'b0 || bus.done !== 4'b0000) begin
      failures++; $display("FAIL arst_now: got cs_n=%b gnt=%b dv=%b done=%b expected 1111/0000/0/0000",
                           bus.cs_n, bus.gnt, bus.spi_data_valid, bus.done);
    end
    bus.req = 4'b0011;
    @(posedge clk);
    #1;
    rst = 1'b1;                              // cycle 0
    step(1);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++; $display("FAIL arst_prio: got gnt=%b expected 0001", bus.gnt);
    end
    rst = 1'b0;
    bus.req = 4'b0010;
    step(2);
    rst = 1'b1;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      failures++; $display("FAIL arst_sole: got gnt=%b expected 0010", bus.gnt);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.req_cfg = '0;
    bus.spi_done = 1'b0;
    bus.spi_rx_data = '0;
    test_reset();
    test_single();
    test_timeout();
    test_timeout_coincident();
    test_round_robin();
    test_latched();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
